// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the execute-stage load/store interface.
// Accepts one read or write request at a time, commits stores into a
// word-organised RAM with byte-lane steering, and returns the aligned word
// for loads after WAIT_STATES extra cycles. busy/done feed the stall logic.
// Optional macro MISALIGN_CHECK_EN adds an error output and blocks misaligned
// half/word stores from committing.
module data_mem_responder #(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic [31:0] read_address,
  input  logic        write,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_data
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        error
`endif
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned WS_LOAD_I = (WAIT_STATES == 0) ? 0 : WAIT_STATES - 1;
  localparam logic [3:0] WS_LOAD = 4'(WS_LOAD_I);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept;
  logic          is_wr_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [31:0]   data_q;
  logic [1:0]    size_q;
  logic [31:0]   rdata_q;

  logic [31:0]   req_addr;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] rd_idx;
  logic          rd_op;
  logic          enter_resp;
  logic          commit;
  logic [3:0]    be;
  logic [31:0]   wdat;

  logic [31:0]   mem [MEM_DEPTH];

  logic          unused_addr_bits;
  assign unused_addr_bits = ^{read_address[31:AW+2], read_address[1:0],
                              write_address[31:AW+2]};

  // Write wins over a simultaneous read, so its address is the one latched.
  assign req_addr = write ? write_address : read_address;
  assign req_idx  = req_addr[AW+1:2];

  // Next-state and wait-counter logic for the IDLE/WAIT/RESP sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          accept  = 1'b1;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and request latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        is_wr_q <= write;
        idx_q   <= req_idx;
        lane_q  <= req_addr[1:0];
        data_q  <= write_data;
        size_q  <= size;
      end
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_req;

  // Only stores can be misaligned; byte stores never are.
  always_comb begin
    misalign_req = 1'b0;
    if (write) begin
      if (size == SZ_HALF)      misalign_req = write_address[0];
      else if (size != SZ_BYTE) misalign_req = (write_address[1:0] != 2'b00);
    end
  end

  // Misalignment flag captured with the request.
  always_ff @(posedge clk) begin
    if (reset)       misalign_q <= 1'b0;
    else if (accept) misalign_q <= misalign_req;
  end

  assign error  = (state_q == S_RESP) && misalign_q;
  assign commit = (state_q == S_RESP) && is_wr_q && !reset && !misalign_q;
`else
  assign commit = (state_q == S_RESP) && is_wr_q && !reset;
`endif

  // Byte-lane enables and replicated store data; size 00 behaves as a word.
  always_comb begin
    be   = 4'b1111;
    wdat = data_q;
    case (size_q)
      SZ_BYTE: begin
        be         = '0;
        be[lane_q] = 1'b1;
        wdat       = {4{data_q[7:0]}};
      end
      SZ_HALF: begin
        be   = lane_q[1] ? 4'b1100 : 4'b0011;
        wdat = {2{data_q[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = data_q;
      end
    endcase
  end

  // RAM write port: store commits on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx_q][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  // With zero wait states RESP is entered straight from IDLE, before the
  // request latches hold anything, so the live request is used there.
  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign rd_idx     = (state_q == S_IDLE) ? req_idx : idx_q;
  assign rd_op      = (state_q == S_IDLE) ? !write : !is_wr_q;

  // Load data register: loaded on entry to RESP, held until the next load.
  always_ff @(posedge clk) begin
    if (reset)                    rdata_q <= '0;
    else if (enter_resp && rd_op) rdata_q <= mem[rd_idx];
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP);
  assign read_data = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of data_mem_responder.
// Instance a uses WAIT_STATES=0 and runs a table of store/load vectors;
// instance b uses WAIT_STATES=3 for busy timing, contention and reset cases.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_rd, a_wr, a_busy, a_done, a_err;
  logic [1:0]  a_sz;
  logic [31:0] a_ra, a_wa, a_wd, a_rdata;
  logic        b_rst, b_rd, b_wr, b_busy, b_done, b_err;
  logic [1:0]  b_sz;
  logic [31:0] b_ra, b_wa, b_wd, b_rdata;

  data_mem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(0)) u_a (
    .clk(clk), .reset(a_rst), .read(a_rd), .read_address(a_ra),
    .write(a_wr), .write_address(a_wa), .write_data(a_wd), .size(a_sz),
    .busy(a_busy), .done(a_done), .read_data(a_rdata)
`ifdef MISALIGN_CHECK_EN
    , .error(a_err)
`endif
  );

  data_mem_responder #(.MEM_DEPTH(1024), .WAIT_STATES(3)) u_b (
    .clk(clk), .reset(b_rst), .read(b_rd), .read_address(b_ra),
    .write(b_wr), .write_address(b_wa), .write_data(b_wd), .size(b_sz),
    .busy(b_busy), .done(b_done), .read_data(b_rdata)
`ifdef MISALIGN_CHECK_EN
    , .error(b_err)
`endif
  );

`ifndef MISALIGN_CHECK_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

`ifdef MISALIGN_CHECK_EN
  localparam logic        MIS     = 1'b1;
  localparam logic [31:0] MIS_WORD = 32'h9902_0304;
`else
  localparam logic        MIS     = 1'b0;
  localparam logic [31:0] MIS_WORD = 32'h9900_BEEF;
`endif

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  task automatic drive(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd);
    if (d == 0) begin
      a_rd = rd; a_wr = wr; a_sz = sz; a_ra = ra; a_wa = wa; a_wd = wd;
    end else begin
      b_rd = rd; b_wr = wr; b_sz = sz; b_ra = ra; b_wa = wa; b_wd = wd;
    end
  endtask

  function automatic logic dn(input int d);
    return (d == 0) ? a_done : b_done;
  endfunction

  // One handshake: request in cycle N, wait for done, drop request after it.
  task automatic access(input int d, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdat, output logic e);
    @(negedge clk);
    drive(d, rd, wr, sz, ra, wa, wd);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dn(d) && lat < 20);
    rdat = (d == 0) ? a_rdata : b_rdata;
    e    = (d == 0) ? a_err : b_err;
    @(posedge clk);
    #1 drive(d, 1'b0, 1'b0, 2'b00, '0, '0, '0);
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.sz = sz; v.addr = addr; v.wd = wd;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    vq.push_back(v);
  endtask

  initial begin
    int          lat;
    logic [31:0] rdat;
    logic        e;
    bit          seen_done;

    // name, rd, wr, size, address, write data, read_data expected at done, error
    add("sw_word",      0, 1, 2'b11, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 0);
    add("lw_word",      1, 0, 2'b00, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0);
    add("sw_clr",       0, 1, 2'b11, 32'h0000_0020, 32'h0000_0000, 32'hDEAD_BEEF, 0);
    add("sb_lane1",     0, 1, 2'b01, 32'h0000_0021, 32'h0000_00AA, 32'hDEAD_BEEF, 0);
    add("sb_lane3",     0, 1, 2'b01, 32'h0000_0023, 32'h0000_0055, 32'hDEAD_BEEF, 0);
    add("lw_bytes",     1, 0, 2'b00, 32'h0000_0020, 32'h0,         32'h5500_AA00, 0);
    add("sw_half_base", 0, 1, 2'b11, 32'h0000_0030, 32'h1122_3344, 32'h5500_AA00, 0);
    add("sh_upper",     0, 1, 2'b10, 32'h0000_0032, 32'h0000_BEEF, 32'h5500_AA00, 0);
    add("lw_sh_up",     1, 0, 2'b00, 32'h0000_0030, 32'h0,         32'hBEEF_3344, 0);
    add("sh_lower",     0, 1, 2'b10, 32'h0000_0030, 32'h0000_CAFE, 32'hBEEF_3344, 0);
    add("lw_sh_lo",     1, 0, 2'b00, 32'h0000_0030, 32'h0,         32'hBEEF_CAFE, 0);
    add("sw_wrap",      0, 1, 2'b11, 32'h0000_1000, 32'h1234_5678, 32'hBEEF_CAFE, 0);
    add("lw_wrap",      1, 0, 2'b00, 32'h0000_0000, 32'h0,         32'h1234_5678, 0);
    add("st_size0",     0, 1, 2'b00, 32'h0000_0060, 32'hA5A5_A5A5, 32'h1234_5678, 0);
    add("sb_upper_ign", 0, 1, 2'b01, 32'h0000_0061, 32'hFFFF_FF3C, 32'h1234_5678, 0);
    add("lw_size0",     1, 0, 2'b00, 32'h0000_0060, 32'h0,         32'hA5A5_3CA5, 0);
    add("lw_unaligned", 1, 0, 2'b00, 32'h0000_0063, 32'h0,         32'hA5A5_3CA5, 0);
    add("lw_hi_bits",   1, 0, 2'b00, 32'hFFFF_F010, 32'h0,         32'hDEAD_BEEF, 0);
    add("sw_mis_base",  0, 1, 2'b11, 32'h0000_0070, 32'h0102_0304, 32'hDEAD_BEEF, 0);
    add("sw_mis",       0, 1, 2'b11, 32'h0000_0072, 32'h0000_0001, 32'hDEAD_BEEF, MIS);
    add("sh_mis",       0, 1, 2'b10, 32'h0000_0071, 32'h0000_BEEF, 32'hDEAD_BEEF, MIS);
    add("sb_ok",        0, 1, 2'b01, 32'h0000_0073, 32'h0000_0099, 32'hDEAD_BEEF, 0);
    add("lw_mis",       1, 0, 2'b00, 32'h0000_0070, 32'h0,         MIS_WORD,      0);

    a_rst = 1'b1; b_rst = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, '0, '0, '0);
    drive(1, 1'b0, 1'b0, 2'b00, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_busy",  a_busy,  0);
    chk("rst_a_done",  a_done,  0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_b_busy",  b_busy,  0);
    chk("rst_b_done",  b_done,  0);
    chk("rst_b_rdata", b_rdata, 32'h0);
`ifdef MISALIGN_CHECK_EN
    chk("rst_a_err", a_err, 0);
`endif
    @(posedge clk);
    #1 a_rst = 1'b0; b_rst = 1'b0;

    // Table vectors on the zero-wait-state instance.
    foreach (vq[i]) begin
      access(0, vq[i].rd, vq[i].wr, vq[i].sz, vq[i].addr, vq[i].addr, vq[i].wd, lat, rdat, e);
      chk({vq[i].name, "_lat"},   lat,  1);
      chk({vq[i].name, "_rdata"}, rdat, vq[i].exp_rd);
`ifdef MISALIGN_CHECK_EN
      chk({vq[i].name, "_err"},   e,    vq[i].exp_err);
`endif
    end

    // Three wait states: seed a word, then trace busy/done of a load while a
    // stray write is raised during busy.
    access(1, 1'b0, 1'b1, 2'b11, '0, 32'h40, 32'h0BAD_F00D, lat, rdat, e);
    chk("b_sw_lat", lat, 4);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("b_busy_c%0d", i), b_busy, (i <= 4) ? 1 : 0);
      chk($sformatf("b_done_c%0d", i), b_done, (i == 4) ? 1 : 0);
      if (i == 1) begin
        b_wr = 1'b1; b_wa = 32'h40; b_wd = 32'hFFFF_0000; b_sz = 2'b11;
      end
      if (i == 4) begin
        chk("b_lw_rdata", b_rdata, 32'h0BAD_F00D);
        @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, 2'b00, '0, '0, '0);
      end
    end
    access(1, 1'b1, 1'b0, 2'b00, 32'h40, '0, '0, lat, rdat, e);
    chk("b_busy_wr_ignored", rdat, 32'h0BAD_F00D);

    // Read and write together in IDLE: write performed, read_data untouched.
    access(1, 1'b0, 1'b1, 2'b11, '0, 32'h50, 32'h5050_5050, lat, rdat, e);
    access(1, 1'b1, 1'b1, 2'b11, 32'h50, 32'h54, 32'h7777_7777, lat, rdat, e);
    chk("b_rw_lat",   lat,  4);
    chk("b_rw_rdata", rdat, 32'h0BAD_F00D);
    access(1, 1'b1, 1'b0, 2'b00, 32'h54, '0, '0, lat, rdat, e);
    chk("b_rw_wr_done", rdat, 32'h7777_7777);
    access(1, 1'b1, 1'b0, 2'b00, 32'h50, '0, '0, lat, rdat, e);
    chk("b_rw_other", rdat, 32'h5050_5050);

    // Reset during WAIT discards the pending store.
    access(1, 1'b0, 1'b1, 2'b11, '0, 32'h44, 32'hAAAA_5555, lat, rdat, e);
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 2'b11, '0, 32'h44, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("b_rst_pre_busy", b_busy, 1);
    b_rst = 1'b1;
    drive(1, 1'b0, 1'b0, 2'b00, '0, '0, '0);
    @(negedge clk);
    b_rst = 1'b0;
    chk("b_rst_busy",  b_busy,  0);
    chk("b_rst_rdata", b_rdata, 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b_done) seen_done = 1'b1;
    end
    chk("b_rst_no_done", seen_done, 0);
    access(1, 1'b1, 1'b0, 2'b00, 32'h44, '0, '0, lat, rdat, e);
    chk("b_rst_lat",   lat,  4);
    chk("b_rst_prior", rdat, 32'hAAAA_5555);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the execute-stage load/store interface.
- Accepts the read and write requests that the memory execution unit issues: read_address/read, write_address/write, LSB-justified write data, and the size code.
- Commits writes into a word-organised data RAM with byte-lane steering, and returns aligned read words after a configurable number of wait states.
- Drives the busy/done handshake back toward the pipeline stall logic.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the data RAM (power of two).
- WAIT_STATES, 0, extra cycles between request acceptance and response (0..15).

Ports:
- clk  input  1  core clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- read  input  1  load request (LB/LBU/LH/LHU/LW).
- read_address  input  32  byte address of load.
- write  input  1  store request.
- write_address  input  32  byte address of store.
- write_data  input  32  store data, LSB-justified (byte in [7:0], half in [15:0]).
- size  input  2  00 = load (any width), 01 = byte store, 10 = half store, 11 = word store.
- busy  output  1  request accepted, response pending.
- done  output  1  one-cycle pulse: access complete.
- read_data  output  32  full aligned word at read_address[31:2]; sign/zero extension is not done here.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state IDLE, busy 0, done 0, read_data 0, wait counter 0. RAM contents are not reset.
- Reset mid-operation: the pending access is discarded. A latched write never reaches the RAM.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Accepts when read or write is 1.
  - Latches address, data, size and op type.
  - Goes to WAIT if WAIT_STATES > 0, else to RESP. busy = 1 from the next cycle.
- WAIT:
  - Counter loads WAIT_STATES-1 on accept and decrements each cycle.
  - Goes to RESP when the counter is 0. busy = 1.
- RESP:
  - done = 1 and busy = 1 for exactly one cycle, then IDLE.
  - Write: RAM update occurs at the RESP clock edge.
  - Read: read_data is registered at entry to RESP, is valid while done = 1, and holds until the next read completes.
- Latency: request sampled in cycle N gives done in cycle N+1+WAIT_STATES.
- Handshake:
  - The initiator holds the request stable until done.
  - The initiator deasserts the request in the cycle after done; a request still high in IDLE is treated as a new access.
  - Requests while busy are ignored; no queueing.
- Simultaneous read and write in IDLE: the write is accepted and the read is dropped; the initiator must reissue it.
- Word index = address[log2(MEM_DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo 4*MEM_DEPTH.
- Byte store: lane = write_address[1:0]; only byte[lane] ← write_data[7:0].
- Half store: write_address[1] selects the half; write_data[15:0] is written there; address[0] is ignored.
- Word store: all four bytes ← write_data; address[1:0] is ignored.
- Unwritten lanes are preserved.
- size 00 with write = 1: treated as a word store.
- Read after write to the same word: a read accepted after the write's done returns the updated data.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Adds output port error (1 bit, reset 0).
  - A half store with address[0] = 1, or a word store with address[1:0] ≠ 00, is not committed.
  - error pulses together with done in RESP.
  - Loads are never flagged.
- Undefined:
  - No error port.
  - Misaligned low address bits are ignored as above and the store is committed.

Test Plan:
- Word round trip, WAIT_STATES=0: SW 0xDEADBEEF @0x10 → done at N+1. Then load @0x10 → read_data 0xDEADBEEF with done at N+1.
- Byte lanes: SW 0x00000000 @0x20, SB 0xAA @0x21, SB 0x55 @0x23 → load @0x20 returns 0x5500AA00.
- Half lanes: SW 0x11223344 @0x30, SH 0xBEEF @0x32 → 0xBEEF3344. Then SH 0xCAFE @0x30 → 0xBEEFCAFE.
- Wait states and contention, WAIT_STATES=3:
  - Load at N → busy N+1..N+4, done at N+4 only.
  - A write asserted during busy is ignored.
  - read+write together in IDLE → write performed, read_data unchanged.
- Wrap and reset, MEM_DEPTH=1024:
  - SW 0x12345678 @0x1000 then load @0x0 → 0x12345678.
  - SW 0xFFFFFFFF @0x40 with reset asserted during WAIT → no done. Load @0x40 returns the prior value; busy 0 the cycle after reset.
- MISALIGN_CHECK_EN defined: SW 0x1 @0x42 → done=1, error=1, RAM unchanged. SH @0x41 → error=1. SB @0x43 → error=0, committed.
